// File: rtl/interval_capture_if.sv
// Read-port bundle for interval_capture.
//   rd_valid : head entry present (driven by the FIFO side)
//   rd_data  : head entry, first-word-fall-through
//   rd_ready : consumer accepts the head entry
// master = FIFO side, slave = host/readout side.
interface interval_capture_if #(
    parameter int unsigned COUNT_W = 32
) ();
    logic               rd_valid;
    logic               rd_ready;
    logic [COUNT_W-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/interval_capture.sv
// Captures the final count of each completed measurement (COUNT->IDLE edge of
// the cycle counter) into a FWFT FIFO, with a minimum-count glitch filter and
// saturating statistics.
//   clk_in, rst      : clock, synchronous active-high reset
//   cnt_state        : counter state (0 = IDLE, 1 = COUNT)
//   cnt_count        : counter value; holds the final count in the first IDLE cycle
//   clear            : synchronous flush of FIFO, overflow flag and statistics
//   rd_if            : valid/ready read port (master side)
//   fifo_level       : number of stored entries
//   overflow         : sticky, a valid interval was dropped on a full FIFO
//   captured_total   : intervals written to the FIFO (saturating)
//   rejected_total   : intervals filtered or dropped (saturating)
module interval_capture #(
    parameter int unsigned COUNT_W   = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MIN_COUNT = 0,
    parameter int unsigned STAT_W    = 16
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     cnt_state,
    input  logic [COUNT_W-1:0]       cnt_count,
    input  logic                     clear,
    interval_capture_if.master       rd_if,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [STAT_W-1:0]        captured_total,
    output logic [STAT_W-1:0]        rejected_total
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [COUNT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               prev_state;
    logic               rd_valid_q;

    logic               done;
    logic               below_min;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic               reject;
    logic [LVL_W-1:0]   level_nxt;
    logic [COUNT_W:0]   min_diff;

    // Capture decision for the current cycle; clear suppresses both done and pop.
    always_comb begin
        done      = prev_state && !cnt_state && !clear;
        // Borrow of a one-bit-wider subtraction flags cnt_count < MIN_COUNT
        // without a constant comparison when MIN_COUNT is 0.
        min_diff  = {1'b0, cnt_count} - (COUNT_W + 1)'(MIN_COUNT);
        below_min = min_diff[COUNT_W];
        full      = (fifo_level == LVL_W'(DEPTH));
        pop       = rd_valid_q && rd_if.rd_ready && !clear;
        push      = done && !below_min && (!full || pop);
        drop      = done && !below_min && full && !pop;
        reject    = done && !push;
        level_nxt = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = fifo_level - LVL_W'(1);
        end
    end

    // Control state: pointers, level, flags, statistics.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            prev_state     <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            rd_valid_q     <= 1'b0;
            overflow       <= 1'b0;
            captured_total <= '0;
            rejected_total <= '0;
        end else begin
            // Sampled even during clear so a clear mid-COUNT cannot fake an edge.
            prev_state <= cnt_state;
            if (clear) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                fifo_level     <= '0;
                rd_valid_q     <= 1'b0;
                overflow       <= 1'b0;
                captured_total <= '0;
                rejected_total <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_level <= level_nxt;
                rd_valid_q <= (level_nxt != '0);
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (push && (captured_total != '1)) begin
                    captured_total <= captured_total + STAT_W'(1);
                end
                if (reject && (rejected_total != '1)) begin
                    rejected_total <= rejected_total + STAT_W'(1);
                end
            end
        end
    end

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk_in) begin
        if (!rst && push) begin
            mem[wr_ptr] <= cnt_count;
        end
    end

    assign rd_if.rd_valid = rd_valid_q;
    assign rd_if.rd_data  = mem[rd_ptr];

endmodule

// File: tb/tb_interval_capture.sv
module tb_interval_capture;

    localparam int unsigned COUNT_W   = 16;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned MIN_COUNT = 4;
    localparam int unsigned STAT_W    = 3;
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;
    localparam int          STAT_MAX  = (1 << STAT_W) - 1;

    logic               clk_in = 1'b0;
    logic               rst;
    logic               cnt_state;
    logic [COUNT_W-1:0] cnt_count;
    logic               clear;
    logic [LVL_W-1:0]   fifo_level;
    logic               overflow;
    logic [STAT_W-1:0]  captured_total;
    logic [STAT_W-1:0]  rejected_total;

    interval_capture_if #(.COUNT_W(COUNT_W)) rd_if ();

    interval_capture #(
        .COUNT_W   (COUNT_W),
        .DEPTH     (DEPTH),
        .MIN_COUNT (MIN_COUNT),
        .STAT_W    (STAT_W)
    ) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .cnt_state      (cnt_state),
        .cnt_count      (cnt_count),
        .clear          (clear),
        .rd_if          (rd_if),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .captured_total (captured_total),
        .rejected_total (rejected_total)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the FIFO contents as a queue plus plain integer stats.
    int unsigned exp_q[$];
    bit          m_prev  = 1'b0;
    bit          m_ovf   = 1'b0;
    int          m_cap   = 0;
    int          m_rej   = 0;
    bit          started = 1'b0;

    // 0: rd_ready low, 1: high, 2: random per cycle, 3: set by hand
    int rd_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < STAT_MAX) ? v + 1 : v;
    endfunction

    // Model update at each active edge, from the inputs held during the cycle.
    initial begin
        forever begin
            @(posedge clk_in);
            if (rst) begin
                exp_q.delete();
                m_prev  = 1'b0;
                m_ovf   = 1'b0;
                m_cap   = 0;
                m_rej   = 0;
                started = 1'b1;
            end else begin
                if (clear) begin
                    exp_q.delete();
                    m_ovf = 1'b0;
                    m_cap = 0;
                    m_rej = 0;
                end else if (m_prev && !cnt_state) begin
                    if (int'(cnt_count) < int'(MIN_COUNT)) begin
                        m_rej = sat_inc(m_rej);
                    end else if (exp_q.size() < DEPTH) begin
                        // the monitor has already removed this cycle's pop
                        exp_q.push_back(int'(cnt_count));
                        m_cap = sat_inc(m_cap);
                    end else begin
                        m_ovf = 1'b1;
                        m_rej = sat_inc(m_rej);
                    end
                end
                m_prev = cnt_state;
            end
        end
    end

    // Monitor: mid-cycle compare of the visible state and of each popped entry.
    initial begin
        forever begin
            @(negedge clk_in);
            if (started) begin
                chk("rd_valid", 64'(rd_if.rd_valid), 64'(exp_q.size() != 0));
                chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
                chk("overflow", 64'(overflow), 64'(m_ovf));
                chk("captured_total", 64'(captured_total), 64'(m_cap));
                chk("rejected_total", 64'(rejected_total), 64'(m_rej));
                if (!rst && !clear && rd_if.rd_ready && exp_q.size() != 0) begin
                    chk("rd_data", 64'(rd_if.rd_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cyc(input bit st, input int cnt);
        cnt_state = st;
        cnt_count = COUNT_W'(cnt);
        case (rd_mode)
            0:       rd_if.rd_ready = 1'b0;
            1:       rd_if.rd_ready = 1'b1;
            2:       rd_if.rd_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
        step();
    endtask

    // One measurement: len COUNT cycles, then gap IDLE cycles holding val.
    task automatic measure(input int len, input int val, input int gap);
        for (int i = 0; i < len; i++) cyc(1'b1, i);
        for (int i = 0; i < gap; i++) cyc(1'b0, val);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1'b0, 0);
        clear = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        clear          = 1'b0;
        cnt_state      = 1'b0;
        cnt_count      = '0;
        rd_if.rd_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_valid", 64'(rd_if.rd_valid), 64'd0);
        chk("reset_level", 64'(fifo_level), 64'd0);
        chk("reset_stats", 64'({captured_total, rejected_total, overflow}), 64'd0);

        // Single capture, one cycle after cnt_state falls.
        rd_mode = 0;
        measure(5, 5, 1);
        chk("t1_valid", 64'(rd_if.rd_valid), 64'd1);
        chk("t1_data", 64'(rd_if.rd_data), 64'd5);
        chk("t1_level", 64'(fifo_level), 64'd1);
        chk("t1_captured", 64'(captured_total), 64'd1);
        rd_mode = 1;
        repeat (2) cyc(1'b0, 0);

        // Glitch filter.
        do_clear();
        rd_mode = 0;
        measure(3, 3, 2);
        measure(10, 10, 1);
        chk("t2_level", 64'(fifo_level), 64'd1);
        chk("t2_data", 64'(rd_if.rd_data), 64'd10);
        chk("t2_rejected", 64'(rejected_total), 64'd1);
        chk("t2_captured", 64'(captured_total), 64'd1);
        rd_mode = 1;
        repeat (2) cyc(1'b0, 0);

        // Overflow on the ninth interval; read-out order checked by the monitor.
        do_clear();
        rd_mode = 0;
        for (int v = 1; v <= 9; v++) measure(3, 100 + v, 2);
        chk("t3_level", 64'(fifo_level), 64'd8);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_rejected", 64'(rejected_total), 64'd1);
        chk("t3_captured_sat", 64'(captured_total), 64'(STAT_MAX));
        rd_mode = 1;
        repeat (10) cyc(1'b0, 0);

        // Full FIFO with a pop on the done cycle.
        do_clear();
        rd_mode = 0;
        for (int v = 11; v <= 18; v++) measure(2, v, 2);
        rd_mode = 3;
        rd_if.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, i);
        rd_if.rd_ready = 1'b1;
        cyc(1'b0, 42);
        rd_if.rd_ready = 1'b0;
        chk("t4_level", 64'(fifo_level), 64'd8);
        chk("t4_overflow", 64'(overflow), 64'd0);
        chk("t4_rejected", 64'(rejected_total), 64'd0);
        rd_mode = 1;
        repeat (7) cyc(1'b0, 0);
        chk("t4_last", 64'(rd_if.rd_data), 64'd42);
        chk("t4_last_level", 64'(fifo_level), 64'd1);
        repeat (2) cyc(1'b0, 0);

        // Clear coincident with done.
        do_clear();
        rd_mode = 0;
        for (int v = 30; v < 33; v++) measure(2, v, 2);
        for (int i = 0; i < 3; i++) cyc(1'b1, i);
        clear = 1'b1;
        cyc(1'b0, 77);
        clear = 1'b0;
        chk("t5_level", 64'(fifo_level), 64'd0);
        chk("t5_valid", 64'(rd_if.rd_valid), 64'd0);
        chk("t5_stats", 64'({captured_total, rejected_total, overflow}), 64'd0);
        repeat (3) cyc(1'b0, 77);
        chk("t5_stays_empty", 64'(fifo_level), 64'd0);

        // Clear during COUNT, then a real completion is still captured.
        cyc(1'b1, 0);
        clear = 1'b1;
        cyc(1'b1, 1);
        clear = 1'b0;
        measure(2, 55, 1);
        chk("t5b_level", 64'(fifo_level), 64'd1);
        chk("t5b_data", 64'(rd_if.rd_data), 64'd55);

        // Statistics saturation with reads enabled.
        do_clear();
        rd_mode = 1;
        for (int v = 20; v < 29; v++) measure(2, v, 2);
        chk("t6_captured_sat", 64'(captured_total), 64'(STAT_MAX));
        chk("t6_level", 64'(fifo_level), 64'd0);

        // Reset mid-measurement, counter reset alongside.
        for (int i = 0; i < 3; i++) cyc(1'b1, i);
        rst = 1'b1;
        cyc(1'b0, 0);
        rst = 1'b0;
        repeat (2) cyc(1'b0, 0);
        chk("t7_level", 64'(fifo_level), 64'd0);
        chk("t7_captured", 64'(captured_total), 64'd0);

        // Randomized traffic: short gaps, back-to-back intervals, stalls, clears.
        for (int n = 0; n < 300; n++) begin
            if (n % 20 == 0) rd_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
            if ($urandom_range(0, 39) == 0) do_clear();
            measure(int'($urandom_range(1, 6)), int'($urandom_range(0, 20)),
                    int'($urandom_range(1, 4)));
        end
        rd_mode = 1;
        repeat (DEPTH + 4) cyc(1'b0, 0);
        chk("final_level", 64'(fifo_level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
